// File: rtl/x_mem_p.sv
// Slice-organised single-port synchronous memory with per-slice write masking and read-valid strobe.
// Define X_MEM_P_INIT_EN to compile in the power-up clear sweep that writes INIT_VAL to every word.
module x_mem_p #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 6,
  parameter int SLICE_W = 2,
  localparam int NSLICE = DATA_W / SLICE_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [NSLICE-1:0] i_wmask,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ready,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              ready;
  logic              sweep_act;
  logic [ADDR_W-1:0] sweep_addr;
  logic              acc;

`ifdef X_MEM_P_INIT_EN
  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] sweep_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_INIT;
      sweep_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == S_INIT && sweep_cnt == '1) state_nxt = S_RUN;
  end

  always_comb begin
    ready      = (state == S_RUN);
    sweep_act  = (state == S_INIT);
    sweep_addr = sweep_cnt;
  end
`else
  logic ready_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) ready_q <= 1'b0;
    else       ready_q <= 1'b1;
  end

  assign ready      = ready_q;
  assign sweep_act  = 1'b0;
  assign sweep_addr = '0;
`endif

  assign o_ready = ready;
  assign acc     = i_req & ready;

  logic              vld_p0;
  logic              vld_p1;
  logic              vld_p2;
  logic [DATA_W-1:0] rdata_p1;
  logic [DATA_W-1:0] rdata_p2;

  // p0: accepted request captured; only reads carry a valid flag forward
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= acc & ~i_we;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    logic                  wen_p0;
    logic [ADDR_W-1:0]     addr_p0;
    logic [SLICE_W-1:0]    wdata_p0;
    logic [SLICE_W-1:0]    rd_p1;
    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_addr;
    logic [SLICE_W-1:0]    ram_wdata;
    logic [SLICE_W-1:0]    mem [DEPTH];

    // p0: per-slice input register
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        wen_p0   <= 1'b0;
        addr_p0  <= '0;
        wdata_p0 <= '0;
      end else begin
        wen_p0   <= acc & i_we & i_wmask[k];
        addr_p0  <= i_addr;
        wdata_p0 <= i_wdata[k*SLICE_W +: SLICE_W];
      end
    end

    // The sweep owns the write port while it runs; no request can be in flight then.
    assign ram_we    = sweep_act | wen_p0;
    assign ram_addr  = sweep_act ? sweep_addr : addr_p0;
    assign ram_wdata = sweep_act ? INIT_VAL[k*SLICE_W +: SLICE_W] : wdata_p0;

    always_ff @(posedge i_clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    // p1: read-first slice output register
    always_ff @(posedge i_clk) begin
      if (i_rst) rd_p1 <= '0;
      else       rd_p1 <= mem[addr_p0];
    end

    assign rdata_p1[k*SLICE_W +: SLICE_W] = rd_p1;
  end

  // p2: output register, updated only by reads so o_rdata holds otherwise
  always_ff @(posedge i_clk) begin
    if (i_rst)       rdata_p2 <= '0;
    else if (vld_p1) rdata_p2 <= rdata_p1;
  end

  assign o_rvalid = vld_p2;
  assign o_rdata  = rdata_p2;

endmodule

// File: tb/tb_x_mem_p.sv
// Bench for x_mem_p: directed vector table, back-to-back and reset corner cases, then random traffic
// checked every cycle against a queue-based reference model of the memory.
module tb_x_mem_p;

  localparam int AW    = 4;
  localparam int DW    = 6;
  localparam int SW    = 2;
  localparam int NS    = DW / SW;
  localparam int DEPTH = 2 ** AW;
  localparam logic [DW-1:0] INIT = 6'h00;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [NS-1:0] wmask;
  logic [DW-1:0] wdata;
  logic          ready;
  logic          rvalid;
  logic [DW-1:0] rdata;

  always #5 clk = ~clk;

  x_mem_p #(.ADDR_W(AW), .DATA_W(DW), .SLICE_W(SW), .INIT_VAL(INIT)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_we    (we),
    .i_addr  (addr),
    .i_wmask (wmask),
    .i_wdata (wdata),
    .o_ready (ready),
    .o_rvalid(rvalid),
    .o_rdata (rdata)
  );

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  logic [DW-1:0] model_mem [DEPTH];
  bit            m_ready   = 1'b0;
  int            sweep_cnt = 0;
  logic [DW-1:0] exp_rdata = '0;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;
  rd_t pend[$];

  typedef struct {
    int            a;
    logic [DW-1:0] pre;
    logic [DW-1:0] wd;
    logic [NS-1:0] m;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the reference model by the same edge, compare outputs.
  task automatic tick(input bit r, input bit q, input bit w, input int a,
                      input logic [NS-1:0] m, input logic [DW-1:0] d);
    bit exp_vld;
    exp_vld = 1'b0;
    rst = r; req = q; we = w; addr = AW'(a); wmask = m; wdata = d;
    @(posedge clk);
    edge_n++;
    if (r) begin
      pend.delete();
      m_ready   = 1'b0;
      sweep_cnt = 0;
      exp_rdata = '0;
    end else begin
      if (pend.size() > 0 && pend[0].due == edge_n) begin
        exp_vld   = 1'b1;
        exp_rdata = pend[0].data;
        void'(pend.pop_front());
      end
      if (!m_ready) begin
`ifdef X_MEM_P_INIT_EN
        model_mem[sweep_cnt] = INIT;
        if (sweep_cnt == DEPTH - 1) m_ready = 1'b1;
        sweep_cnt++;
`else
        m_ready = 1'b1;
`endif
      end else if (q) begin
        if (w) begin
          for (int k = 0; k < NS; k++)
            if (m[k]) model_mem[a][k*SW +: SW] = d[k*SW +: SW];
        end else begin
          pend.push_back('{edge_n + 2, model_mem[a]});
        end
      end
    end
    #1;
    check("ready", 32'(ready), 32'(m_ready));
    check("rvalid", 32'(rvalid), 32'(exp_vld));
    check("rdata", 32'(rdata), 32'(exp_rdata));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 0, '0, '0);
  endtask

  initial begin
    tbl[0] = '{5,  6'h00, 6'h2A, 3'b111, 6'h2A};
    tbl[1] = '{9,  6'h3F, 6'h00, 3'b010, 6'h33};
    tbl[2] = '{3,  6'h00, 6'h3F, 3'b001, 6'h03};
    tbl[3] = '{7,  6'h15, 6'h2A, 3'b100, 6'h25};
    tbl[4] = '{12, 6'h2A, 6'h15, 3'b000, 6'h2A};
    tbl[5] = '{0,  6'h3F, 6'h00, 3'b101, 6'h0C};

    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 0, '0, '0);

    // First cycle out of reset: o_ready is still low, so this write must be dropped.
    tick(1'b0, 1'b1, 1'b1, 4, 3'b111, 6'h3F);
`ifdef X_MEM_P_INIT_EN
    tick(1'b0, 1'b1, 1'b1, 0, 3'b111, 6'h3F);
    tick(1'b0, 1'b1, 1'b0, 0, 3'b111, 6'h00);
    idle(13);
    for (int i = 0; i < DEPTH; i++) tick(1'b0, 1'b1, 1'b0, i, '0, '0);
    idle(3);
`else
    for (int i = 0; i < DEPTH; i++) tick(1'b0, 1'b1, 1'b1, i, 3'b111, DW'(i * 5 + 1));
`endif

    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1, 1'b1, tbl[i].a, 3'b111, tbl[i].pre);
      tick(1'b0, 1'b1, 1'b1, tbl[i].a, tbl[i].m, tbl[i].wd);
      tick(1'b0, 1'b1, 1'b0, tbl[i].a, '0, '0);
      idle(2);
      check("tbl_rdata", 32'(rdata), 32'(tbl[i].exp));
      check("tbl_rvalid", 32'(rvalid), 32'd1);
    end

    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, i, 3'b111, DW'(i + 1));
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, i, '0, '0);
    idle(4);

    tick(1'b0, 1'b1, 1'b0, 4, '0, '0);
    tick(1'b0, 1'b1, 1'b0, 5, '0, '0);
    tick(1'b1, 1'b0, 1'b0, 0, '0, '0);
`ifdef X_MEM_P_INIT_EN
    idle(20);
`else
    idle(5);
`endif

    for (int i = 0; i < 400; i++) begin
      bit            r;
      bit            q;
      bit            w;
      logic [NS-1:0] m;
      r = ($urandom_range(0, 63) == 0);
      q = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      m = NS'($urandom);
      tick(r, q, w, int'($urandom_range(0, DEPTH - 1)), m, DW'($urandom));
    end
    idle(24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
